// File: rtl/riscv_membus_arb.sv
// Arbitrates instruction-fetch and data ports onto one shared memory port.
// Data wins by default; a waiting fetch is forced through after STARVE_LIMIT data grants.
module riscv_membus_arb #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            im_req,
    input  logic [XLEN-1:0] im_adr,
    output logic            im_ack,
    output logic            im_err,
    output logic [XLEN-1:0] im_q,
    input  logic            dm_req,
    input  logic [XLEN-1:0] dm_adr,
    input  logic [XLEN-1:0] dm_d,
    input  logic            dm_we,
    input  logic [2:0]      dm_size,
    output logic            dm_ack,
    output logic            dm_err,
    output logic [XLEN-1:0] dm_q,
    output logic            bus_req,
    output logic [XLEN-1:0] bus_adr,
    output logic [XLEN-1:0] bus_d,
    output logic            bus_we,
    output logic [2:0]      bus_size,
    input  logic            bus_ack,
    input  logic            bus_err,
    input  logic [XLEN-1:0] bus_q,
    output logic [1:0]      arb_owner
);

    // A zero limit still needs a one-bit counter to keep the logic well formed.
    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT_C   = CNT_W'(STARVE_LIMIT);
    localparam logic [2:0]       SIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_IGNT = 2'b01,
        ST_DGNT = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_nxt;
    logic             w_data_wins;
    logic             w_done;

    assign w_data_wins = dm_req && (!im_req || (r_starve_cnt < LIMIT_C));
    assign w_done      = bus_ack || bus_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        im_ack       = 1'b0;
        im_err       = 1'b0;
        dm_ack       = 1'b0;
        dm_err       = 1'b0;
        bus_req      = 1'b0;
        bus_adr      = '0;
        bus_d        = '0;
        bus_we       = 1'b0;
        bus_size     = 3'b000;
        arb_owner    = r_state;

        case (r_state)
            ST_IDLE: begin
                if (w_data_wins) begin
                    w_state_nxt = ST_DGNT;
                    if (!im_req) begin
                        w_starve_nxt = '0;
                    end else if (r_starve_cnt < LIMIT_C) begin
                        w_starve_nxt = r_starve_cnt + CNT_W'(1);
                    end
                end else if (im_req) begin
                    w_state_nxt  = ST_IGNT;
                    w_starve_nxt = '0;
                end
            end
            ST_IGNT: begin
                bus_req  = 1'b1;
                bus_adr  = im_adr;
                bus_size = SIZE_WORD;
                im_ack   = bus_ack;
                im_err   = bus_err;
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DGNT: begin
                bus_req  = 1'b1;
                bus_adr  = dm_adr;
                bus_d    = dm_d;
                bus_we   = dm_we;
                bus_size = dm_size;
                dm_ack   = bus_ack;
                dm_err   = bus_err;
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign im_q = bus_q;
    assign dm_q = bus_q;

endmodule

// File: tb/tb_riscv_membus_arb.sv
// Checks two arbiters (starve limit 4 and 0) against a cycle model, a directed
// vector table and a starvation-order sequence.
module tb_riscv_membus_arb;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OV_W = 2 + 4 + 2 + 3 + 4 * XLEN;
    localparam int unsigned TV_W = 2 + 4 + 2 + 2 * XLEN;
    localparam logic [XLEN-1:0] A_IM = 32'h0000_0200;
    localparam logic [XLEN-1:0] A_DM = 32'h0000_1000;
    localparam logic [XLEN-1:0] D_WR = 32'hDEAD_BEEF;

    logic            clk = 1'b0;
    logic            rst, im_req, dm_req, dm_we, bus_ack, bus_err;
    logic [XLEN-1:0] im_adr, dm_adr, dm_d, bus_q;
    logic [2:0]      dm_size;

    logic            a_im_ack, a_im_err, a_dm_ack, a_dm_err, a_bus_req, a_bus_we;
    logic [XLEN-1:0] a_im_q, a_dm_q, a_bus_adr, a_bus_d;
    logic [2:0]      a_bus_size;
    logic [1:0]      a_owner;
    logic            b_im_ack, b_im_err, b_dm_ack, b_dm_err, b_bus_req, b_bus_we;
    logic [XLEN-1:0] b_im_q, b_dm_q, b_bus_adr, b_bus_d;
    logic [2:0]      b_bus_size;
    logic [1:0]      b_owner;

    always #5 clk = ~clk;

    riscv_membus_arb #(.XLEN(XLEN), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .rst(rst),
        .im_req(im_req), .im_adr(im_adr), .im_ack(a_im_ack), .im_err(a_im_err), .im_q(a_im_q),
        .dm_req(dm_req), .dm_adr(dm_adr), .dm_d(dm_d), .dm_we(dm_we), .dm_size(dm_size),
        .dm_ack(a_dm_ack), .dm_err(a_dm_err), .dm_q(a_dm_q),
        .bus_req(a_bus_req), .bus_adr(a_bus_adr), .bus_d(a_bus_d), .bus_we(a_bus_we),
        .bus_size(a_bus_size), .bus_ack(bus_ack), .bus_err(bus_err), .bus_q(bus_q),
        .arb_owner(a_owner)
    );

    riscv_membus_arb #(.XLEN(XLEN), .STARVE_LIMIT(0)) u_dut_fp (
        .clk(clk), .rst(rst),
        .im_req(im_req), .im_adr(im_adr), .im_ack(b_im_ack), .im_err(b_im_err), .im_q(b_im_q),
        .dm_req(dm_req), .dm_adr(dm_adr), .dm_d(dm_d), .dm_we(dm_we), .dm_size(dm_size),
        .dm_ack(b_dm_ack), .dm_err(b_dm_err), .dm_q(b_dm_q),
        .bus_req(b_bus_req), .bus_adr(b_bus_adr), .bus_d(b_bus_d), .bus_we(b_bus_we),
        .bus_size(b_bus_size), .bus_ack(bus_ack), .bus_err(bus_err), .bus_q(bus_q),
        .arb_owner(b_owner)
    );

    logic [OV_W-1:0] act [2];
    assign act[0] = {a_owner, a_im_ack, a_im_err, a_dm_ack, a_dm_err, a_bus_req, a_bus_we,
                     a_bus_size, a_bus_adr, a_bus_d, a_im_q, a_dm_q};
    assign act[1] = {b_owner, b_im_ack, b_im_err, b_dm_ack, b_dm_err, b_bus_req, b_bus_we,
                     b_bus_size, b_bus_adr, b_bus_d, b_im_q, b_dm_q};

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: owner 0 none / 1 fetch / 2 data; wins counts data grants
    // taken in a row while a fetch was left waiting.
    int m_own  [2] = '{0, 0};
    int m_wins [2] = '{0, 0};
    int lim    [2] = '{4, 0};
    bit im_done, dm_done;

    typedef struct {
        logic            rst, im, dm, we, ack, err;
        logic [1:0]      own;
        logic            iack, ierr, dack, derr, breq, bwe;
        logic [XLEN-1:0] badr, bd;
    } vec_t;

    vec_t vecs [25];

    function automatic vec_t mk(input logic r, i, d, w, k, e, input logic [1:0] o,
                                input logic ia, ie, da, de, br, bw,
                                input logic [XLEN-1:0] ad, dd);
        vec_t v;
        v.rst = r; v.im = i; v.dm = d; v.we = w; v.ack = k; v.err = e; v.own = o;
        v.iack = ia; v.ierr = ie; v.dack = da; v.derr = de; v.breq = br; v.bwe = bw;
        v.badr = ad; v.bd = dd;
        return v;
    endfunction

    function automatic logic [OV_W-1:0] expect_vec(input int own);
        logic            fi, da;
        logic [XLEN-1:0] adr, d;
        logic [2:0]      sz;
        fi  = (own == 1);
        da  = (own == 2);
        adr = fi ? im_adr : (da ? dm_adr : '0);
        d   = da ? dm_d : '0;
        sz  = fi ? 3'b010 : (da ? dm_size : 3'b000);
        return {2'(own), fi & bus_ack, fi & bus_err, da & bus_ack, da & bus_err,
                fi | da, da & dm_we, sz, adr, d, bus_q, bus_q};
    endfunction

    task automatic cmp(input string nm, input logic [OV_W-1:0] a, input logic [OV_W-1:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, a, e);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            cmp($sformatf("model_lim%0d", lim[k]), act[k], expect_vec(m_own[k]));
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_own[k]  = 0;
                m_wins[k] = 0;
            end else if (m_own[k] != 0) begin
                if (bus_ack || bus_err) m_own[k] = 0;
            end else if (dm_req && !(im_req && m_wins[k] >= lim[k])) begin
                m_own[k]  = 2;
                m_wins[k] = im_req ? ((m_wins[k] < lim[k]) ? m_wins[k] + 1 : lim[k]) : 0;
            end else if (im_req) begin
                m_own[k]  = 1;
                m_wins[k] = 0;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst || (m_own[0] == 1 && (bus_ack || bus_err))) im_done = 1'b1;
        if (rst || (m_own[0] == 2 && (bus_ack || bus_err))) dm_done = 1'b1;
        model_step();
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int        order [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
        int        ng;
        vec_t      v;
        logic [TV_W-1:0] ta, te;

        rst = 1'b1; im_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_q = '0;
        im_adr = A_IM; dm_adr = A_DM; dm_d = D_WR; dm_size = 3'b010;
        im_done = 1'b0; dm_done = 1'b0;
        advance();

        //             rst im dm we ak er own ia ie da de br bw  badr  bd
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0,   '0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0,   '0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, A_IM, '0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, A_IM, '0);
        vecs[4]  = mk(0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, A_IM, '0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0,   '0);
        vecs[6]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, '0,   '0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0,   '0);
        vecs[8]  = mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0,   '0);
        vecs[9]  = mk(0, 1, 1, 1, 0, 0, 2, 0, 0, 0, 0, 1, 1, A_DM, D_WR);
        vecs[10] = mk(0, 1, 1, 1, 1, 0, 2, 0, 0, 1, 0, 1, 1, A_DM, D_WR);
        vecs[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0,   '0);
        vecs[12] = mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, A_IM, '0);
        vecs[13] = mk(0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, A_IM, '0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0,   '0);
        vecs[15] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0,   '0);
        vecs[16] = mk(0, 0, 1, 0, 0, 1, 2, 0, 0, 0, 1, 1, 0, A_DM, D_WR);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0,   '0);
        vecs[18] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0,   '0);
        vecs[19] = mk(1, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0, A_DM, D_WR);
        vecs[20] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, '0,   '0);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0,   '0);
        vecs[22] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0,   '0);
        vecs[23] = mk(1, 0, 1, 0, 1, 0, 2, 0, 0, 1, 0, 1, 0, A_DM, D_WR);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0,   '0);

        foreach (vecs[i]) begin
            v = vecs[i];
            rst = v.rst; im_req = v.im; dm_req = v.dm; dm_we = v.we;
            bus_ack = v.ack; bus_err = v.err; bus_q = $urandom;
            #1;
            check_model();
            ta = {a_owner, a_im_ack, a_im_err, a_dm_ack, a_dm_err, a_bus_req, a_bus_we,
                  a_bus_adr, a_bus_d};
            te = {v.own, v.iack, v.ierr, v.dack, v.derr, v.breq, v.bwe, v.badr, v.bd};
            cmp($sformatf("vec%0d", i), OV_W'(ta), OV_W'(te));
            advance();
        end

        // Both requesters held with instant acks: grant order must repeat D,D,D,D,I.
        rst = 1'b1; im_req = 1'b0; dm_req = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
        #1; check_model();
        advance();
        rst = 1'b0; im_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; bus_ack = 1'b1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 10; c++) begin
            bus_q = $urandom;
            #1;
            check_model();
            if (a_owner != 2'b00) begin
                cmp($sformatf("starve_grant%0d", ng), OV_W'(a_owner), OV_W'(order[ng]));
                ng++;
            end
            advance();
        end
        if (ng < 10) begin
            n_chk++; n_fail++;
            $display("FAIL starve_timeout grants=%0d want=10", ng);
        end

        // Randomized traffic with requesters that hold until completion.
        im_req = 1'b0; dm_req = 1'b0; bus_ack = 1'b0;
        im_done = 1'b0; dm_done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!im_req || im_done) begin
                im_req = ($urandom_range(0, 2) == 0);
                im_adr = $urandom;
            end
            if (!dm_req || dm_done) begin
                dm_req  = ($urandom_range(0, 1) == 0);
                dm_adr  = $urandom;
                dm_d    = $urandom;
                dm_we   = 1'($urandom_range(0, 1));
                dm_size = 3'($urandom_range(0, 7));
            end
            im_done = 1'b0;
            dm_done = 1'b0;
            bus_ack = ($urandom_range(0, 3) == 0);
            bus_err = ($urandom_range(0, 11) == 0);
            bus_q   = $urandom;
            #1;
            check_model();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
